// File: rtl/reg_bus_master_pkg.sv
// Shared types and defaults for the Wishbone-to-register-bus initiator.
package reg_bus_pkg;
   typedef enum logic [1:0] {IDLE, REQ, DONE} reg_mst_state_t;

   localparam logic [31:0] REG_ERR_DATA = 32'hDEAD_0BAD;
   localparam int          REG_TMO_DEF  = 255;
endpackage

// File: rtl/reg_bus_master_if.sv
// Wishbone slave side and peripheral register-bus side of reg_bus_master.
interface reg_bus_master_if #(parameter int AW = 11);
   logic          wbs_cyc_i;
   logic          wbs_stb_i;
   logic          wbs_we_i;
   logic [AW-1:0] wbs_adr_i;
   logic [31:0]   wbs_dat_i;
   logic [3:0]    wbs_sel_i;
   logic [31:0]   wbs_dat_o;
   logic          wbs_ack_o;
   logic          wbs_err_o;
   logic          reg_cs;
   logic          reg_wr;
   logic [AW-1:0] reg_addr;
   logic [31:0]   reg_wdata;
   logic [3:0]    reg_be;
   logic [31:0]   reg_rdata;
   logic          reg_ack;

   modport master (
      input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_adr_i, wbs_dat_i, wbs_sel_i,
      input  reg_rdata, reg_ack,
      output wbs_dat_o, wbs_ack_o, wbs_err_o,
      output reg_cs, reg_wr, reg_addr, reg_wdata, reg_be
   );

   modport slave (
      output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_adr_i, wbs_dat_i, wbs_sel_i,
      output reg_rdata, reg_ack,
      input  wbs_dat_o, wbs_ack_o, wbs_err_o,
      input  reg_cs, reg_wr, reg_addr, reg_wdata, reg_be
   );
endinterface

// File: rtl/reg_bus_master_tmo.sv
// Saturating response-timeout counter; expire flags the last allowed REQ cycle.
module reg_bus_tmo #(
   parameter int TMO_W   = 8,
   parameter int TMO_CYC = 255
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic expire
);
   localparam logic [TMO_W-1:0] CNT_MAX  = TMO_W'(TMO_CYC);
   localparam logic [TMO_W-1:0] CNT_LAST = TMO_W'(TMO_CYC - 1);

   logic [TMO_W-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                     cnt <= '0;
      else if (clr)                   cnt <= '0;
      else if (en && cnt != CNT_MAX)  cnt <= cnt + 1'b1;
   end

   assign expire = en && (cnt == CNT_LAST);
endmodule

// File: rtl/reg_bus_master.sv
// Wishbone slave to register-bus initiator, one outstanding transaction.
// REG_BUS_MASTER_TMO_EN enables the response timeout, wbs_err_o and tmo_flag.
module reg_bus_master
   import reg_bus_pkg::*;
#(
   parameter int          AW       = 11,
   parameter int          TMO_W    = 8,
   parameter int          TMO_CYC  = REG_TMO_DEF,
   parameter logic [31:0] ERR_DATA = REG_ERR_DATA
) (
   input  logic             mclk,
   input  logic             h_reset_n,
   reg_bus_master_if.master bus,
   output logic             tmo_flag
);
   reg_mst_state_t state, state_nxt;
   logic accept, fin_ack, fin_tmo, expire;

   if ((TMO_CYC < 1) || (TMO_CYC > (2**TMO_W) - 1)) begin : g_bad_tmo
      $error("reg_bus_master: TMO_CYC must be within 1..2^TMO_W-1");
   end

   always_ff @(posedge mclk or negedge h_reset_n) begin
      if (!h_reset_n) state <= IDLE;
      else            state <= state_nxt;
   end

   // reg_ack is only looked at in REQ; ack beats a same-cycle expiry
   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      fin_ack   = 1'b0;
      fin_tmo   = 1'b0;
      case (state)
         IDLE: if (bus.wbs_cyc_i && bus.wbs_stb_i) begin
            accept    = 1'b1;
            state_nxt = REQ;
         end
         REQ: if (bus.reg_ack) begin
            fin_ack   = 1'b1;
            state_nxt = DONE;
         end else if (expire) begin
            fin_tmo   = 1'b1;
            state_nxt = DONE;
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge mclk or negedge h_reset_n) begin
      if (!h_reset_n) begin
         bus.reg_cs    <= 1'b0;
         bus.reg_wr    <= 1'b0;
         bus.reg_addr  <= '0;
         bus.reg_wdata <= '0;
         bus.reg_be    <= '0;
         bus.wbs_dat_o <= '0;
         bus.wbs_ack_o <= 1'b0;
         bus.wbs_err_o <= 1'b0;
      end else begin
         // a dropped cycle still completes on the register bus, silently
         bus.wbs_ack_o <= fin_ack && bus.wbs_cyc_i;
         bus.wbs_err_o <= fin_tmo && bus.wbs_cyc_i;
         if (accept) begin
            bus.reg_cs    <= 1'b1;
            bus.reg_wr    <= bus.wbs_we_i;
            bus.reg_addr  <= bus.wbs_adr_i;
            bus.reg_wdata <= bus.wbs_dat_i;
            bus.reg_be    <= bus.wbs_sel_i;
         end else if (fin_ack || fin_tmo) begin
            bus.reg_cs <= 1'b0;
         end
         if (fin_ack)      bus.wbs_dat_o <= bus.reg_wr ? 32'h0 : bus.reg_rdata;
         else if (fin_tmo) bus.wbs_dat_o <= bus.reg_wr ? 32'h0 : ERR_DATA;
      end
   end

`ifdef REG_BUS_MASTER_TMO_EN
   logic tmo_q;

   reg_bus_tmo #(.TMO_W(TMO_W), .TMO_CYC(TMO_CYC)) u_tmo (
      .clk    (mclk),
      .rst_n  (h_reset_n),
      .clr    (accept),
      .en     (state == REQ),
      .expire (expire)
   );

   always_ff @(posedge mclk or negedge h_reset_n) begin
      if (!h_reset_n)   tmo_q <= 1'b0;
      else if (accept)  tmo_q <= 1'b0;
      else if (fin_tmo) tmo_q <= 1'b1;
   end

   assign tmo_flag = tmo_q;
`else
   assign expire   = 1'b0;
   assign tmo_flag = 1'b0;
`endif
endmodule

// File: doc/reg_bus_master.md
Name: reg_bus_master

Overview:
- Wishbone-slave to register-bus initiator. It drives the peripheral register bus (reg_cs/reg_wr/reg_addr/reg_wdata/reg_be) and consumes reg_rdata/reg_ack.
- It converts one pipelined Wishbone access into one held register-bus transaction, and returns the read data and the ack.
- It sits between the Wishbone interconnect and the peripheral tops (digital-to-analog, RTC, IR register banks).
- There is at most one outstanding transaction.

Parameters:
- AW, 11, register-bus byte address width.
- TMO_W, 8, width of the response-timeout counter.
- TMO_CYC, 255, number of REQ cycles without reg_ack before timeout; must be ≤ 2^TMO_W-1.
- ERR_DATA, 32'hDEAD_0BAD, value placed on wbs_dat_o on a timed-out read.

Ports:
- mclk  in  1  system clock (single clock domain).
- h_reset_n  in  1  asynchronous, active-low reset.
- wbs_cyc_i  in  1  Wishbone cycle.
- wbs_stb_i  in  1  Wishbone strobe.
- wbs_we_i  in  1  1 = write.
- wbs_adr_i  in  AW  byte address.
- wbs_dat_i  in  32  write data.
- wbs_sel_i  in  4  byte enables.
- wbs_dat_o  out  32  read data, valid with wbs_ack_o.
- wbs_ack_o  out  1  one-cycle completion pulse.
- wbs_err_o  out  1  one-cycle timeout-error pulse.
- reg_cs  out  1  register chip select, held until reg_ack.
- reg_wr  out  1  write strobe qualifier.
- reg_addr  out  AW  register address.
- reg_wdata  out  32  write data.
- reg_be  out  4  byte enables.
- reg_rdata  in  32  read data, sampled with reg_ack.
- reg_ack  in  1  responder ack.
- tmo_flag  out  1  sticky timeout indicator; cleared by the next accepted request.

Behaviour:
- Reset (async, h_reset_n=0): state IDLE. All outputs 0, including wbs_dat_o, reg_addr, reg_wdata, reg_be and tmo_flag. Reset mid-transaction abandons it with no ack and no err.
- FSM states:
  - IDLE: accept when wbs_cyc_i & wbs_stb_i. Register we/adr/dat/sel onto reg_wr/reg_addr/reg_wdata/reg_be and set reg_cs=1 on the next edge. Go to REQ. Clear tmo_flag.
  - REQ: reg_cs and all request fields are held stable. Wishbone inputs are not resampled. TMO counter increments each cycle. On reg_ack=1:
    - reg_cs←0.
    - For a read, wbs_dat_o←reg_rdata; for a write, wbs_dat_o←0.
    - wbs_ack_o←1 if wbs_cyc_i is still high; otherwise the response is discarded.
    - Go to DONE.
  - DONE: the ack/err pulse is high for exactly this one cycle. Requests are ignored. Return to IDLE on the next edge.
- Latency: the earliest reg_cs is 1 cycle after stb. If reg_ack is returned in the first REQ cycle, wbs_ack_o rises 2 cycles after stb. Back-to-back throughput is 1 transaction per 3 cycles minimum.
- reg_wdata/reg_be/reg_wr keep their last values in IDLE; only reg_cs qualifies them.
- reg_ack while reg_cs=0 (IDLE/DONE) is ignored.
- reg_ack on the same cycle the timeout expires: ack wins and no error is raised.
- wbs_cyc_i dropping during REQ does not shorten the register transaction. reg_cs is held until reg_ack (or timeout), then the transaction completes silently.
- Counter reset: cleared on entry to REQ. It does not wrap: it saturates at TMO_CYC.

Optional Feature:
- Macro: REG_BUS_MASTER_TMO_EN.
- Defined:
  - When the REQ counter reaches TMO_CYC with no reg_ack, reg_cs←0 and tmo_flag←1.
  - If wbs_cyc_i is high, wbs_err_o pulses for 1 cycle (no ack), with wbs_dat_o=ERR_DATA for reads and 0 for writes.
  - Go to DONE.
- Undefined: there is no counter and no timeout. REQ waits indefinitely. wbs_err_o and tmo_flag are tied to 0.

Decomposition:
- Shared package reg_bus_pkg:
  - typedef enum logic [1:0] {IDLE, REQ, DONE} reg_mst_state_t.
  - localparam REG_ERR_DATA default.
  - localparam REG_TMO_DEF = 255.
- Sub-module reg_bus_tmo: saturating TMO_W counter with clear/enable inputs and an expire output. It is instantiated only under REG_BUS_MASTER_TMO_EN.

Test Plan:
- Write: adr=11'h084, dat=32'hA5A5_1234, sel=4'hF, responder acks 1 cycle after reg_cs.
  - reg_cs high 1 cycle with reg_wr=1, reg_addr=11'h084, reg_wdata=32'hA5A5_1234.
  - wbs_ack_o pulses exactly once, at 2 cycles after stb.
- Read: adr=11'h100, responder returns 32'h0000_00C3 with ack after 5 cycles.
  - reg_cs held 5 cycles with fields stable.
  - wbs_dat_o=32'h0000_00C3 with a single-cycle wbs_ack_o.
- Back-to-back: 3 reads with stb held continuously.
  - Exactly 3 reg_cs pulses and 3 acks, with ≥1 idle cycle (DONE) between them.
  - No duplicate accept.
- Timeout (macro on, TMO_CYC=8): no reg_ack.
  - reg_cs drops after 8 REQ cycles.
  - wbs_err_o pulses once, wbs_dat_o=32'hDEAD_0BAD, tmo_flag=1.
  - A following successful access clears tmo_flag.
- Abort/reset:
  - wbs_cyc_i dropped mid-REQ, ack after 3 cycles → no wbs_ack_o, FSM back to IDLE.
  - h_reset_n asserted mid-REQ → all outputs 0 immediately; a later reg_ack is ignored.
- Timeout/ack race: reg_ack asserted exactly on the expiry cycle → wbs_ack_o=1, wbs_err_o=0, tmo_flag stays 0.
